egress_fsm: RTL and testbench
=============================

Name: egress_fsm

Overview:
- Transmit-side counterpart of the ingress frame scanner.
- Drains complete 16-bit-word Ethernet frames from the shared frame buffer (first-word-fall-through read port) and drives them onto the egress AXIS interface.
- Checks the leading SFD word, tracks header fields for status, and discards corrupt frames.
- Sits between the frame buffer and the MAC/PHY-side AXIS sink.

Parameters:
- DATA_W, 16, AXIS/buffer word width; must match axis_source_t.tdata.
- SFD_WORD, 16'hAAAB, required first word of every frame.
- CNT_W, 16, width of the tx_frame_cnt and drop_cnt counters.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- buf_empty  in  1  buffer holds no words
- buf_rdata  in  16  head word (valid when !buf_empty)
- buf_rlast  in  1  head word is the last word of its frame
- buf_frame_avail  in  1  at least one complete frame (tlast written) is in the buffer
- buf_rd_en  out  1  pop head word
- buf_frame_done  out  1  pulse: the popped word had buf_rlast=1
- egress_en  in  1  permit starting new frames
- egress_source  out  axis_source_t  tvalid/tdata/tlast
- egress_sink  in  axis_sink_t  tready
- tx_status  out  frame_status  field currently being popped
- tx_frame_cnt  out  CNT_W  frames sent (wraps)
- drop_cnt  out  CNT_W  frames discarded (saturates at all-ones)
- runt_err  out  1  one-cycle pulse: rlast popped before PAYLOAD
- underrun_err  out  1  sticky: buf_empty mid-frame

Behaviour:
- Reset (reset_n=0 at posedge): state IDLE; all outputs 0; slice emptied; counters 0; underrun_err cleared.
- Reset mid-frame abandons the frame with no tlast; the buffer shares the same reset.
- Pop rule: buf_rd_en = active-state & !buf_empty & slice_can_accept. In DISCARD, slice_can_accept is forced to 1.
- A popped word enters the output register slice. It appears on egress_source the next cycle. Latency is 1 cycle.
- Throughput is 1 word/cycle while tready=1. Full throughput is preserved under tready toggling.
- AXIS rules:
  - tvalid, once high, holds with stable tdata/tlast until tready.
  - Within a frame, tvalid never drops while the buffer is non-empty.
- States: IDLE, DST_MAC, SRC_MAC, TYPE, PAYLOAD, DISCARD.
- IDLE: start only when buf_frame_avail & egress_en & !buf_empty & slice_can_accept. Pop the head word.
  - Word == SFD_WORD: forward it; go to DST_MAC.
  - Otherwise: go to DISCARD, not forwarded. If that word has rlast, stay in IDLE and increment drop_cnt.
- DST_MAC: 3 words, then SRC_MAC.
- SRC_MAC: 3 words, then TYPE.
- TYPE: 1 word, then PAYLOAD.
- Header word position is tracked by a 2-bit counter. It clears on every state change and advances only on a pop.
- PAYLOAD: forward until the rlast word is popped; that word carries tlast. Return to IDLE; tx_frame_cnt++.
- Runt frame (rlast popped in DST_MAC, SRC_MAC or TYPE):
  - Forward that word with tlast=1 and go to IDLE.
  - Pulse runt_err; tx_frame_cnt++.
- DISCARD: pop every cycle the buffer is non-empty; forward nothing. On rlast go to IDLE and increment drop_cnt.
- buf_frame_done pulses on every pop with rlast, in all states.
- egress_en deasserted mid-frame: the current frame completes; no new frame starts.
- buf_empty in a non-IDLE state: stall, no pop, set underrun_err. Resume when data returns.
- Back-to-back frames: IDLE may pop the next SFD in the cycle after the previous rlast pop. Gap is at most 1 cycle.
- tx_status encodings (pop side):
  - DST_MAC=5'b00011
  - SRC_MAC=5'b00101
  - TYPE=5'b01001
  - PAYLOAD=5'b10001
  - IDLE/DISCARD=5'b00000
  - In IDLE during the SFD-pop cycle: 5'b00001.
- Counter width rules:
  - tx_frame_cnt wraps from all-ones to 0.
  - drop_cnt holds at all-ones.

Decomposition:
- Shared package: axis_source_t, axis_sink_t, frame_status, SFD constant, header word counts (3/3/1), state encodings.
- State encodings are shared with the ingress scanner for the waveform decode function.
- Sub-module axis_reg_slice: 2-entry full-throughput AXIS register slice.
  - Exposes can_accept = fewer than 2 entries, or one entry leaving this cycle.
  - Reusable on the ingress side.

Test Plan:
- Good frame, tready=1: AAAB, 6 MAC words, type 0800, 3 payload words, last = BEEF. Expect 11 words on egress with tlast only on BEEF; tx_frame_cnt=1; buf_frame_done one pulse; no gap.
- Same frame with tready toggling 1,0,0,1 repeatedly. Expect identical word order, no loss or duplication, tdata stable while stalled.
- First word 1234, frame length 5. Expect no egress tvalid, 5 pops, drop_cnt=1, state back in IDLE. A following good frame is sent normally.
- Runt AAAB,1111,2222(rlast). Expect 3 words out with tlast on 2222; runt_err pulses once; tx_frame_cnt=1.
- egress_en drops on payload word 2 of a 12-word frame. Expect the frame completes; the next queued frame does not start until egress_en=1.
- reset_n low for 1 cycle mid-payload, then buf_empty emptied in a later frame. Expect all outputs 0 after reset; underrun_err sets on the empty stall and stays set until the next reset.

Source files
------------

// File: rtl/egress_fsm_pkg.sv
// Types and constants shared by the egress drainer and the ingress frame scanner
// (the state encoding also feeds the common waveform decode function).
package egress_fsm_pkg;

    localparam int                     AXIS_DATA_W   = 16;
    localparam logic [AXIS_DATA_W-1:0] SFD           = 16'hAAAB;
    localparam int                     DST_MAC_WORDS = 3;
    localparam int                     SRC_MAC_WORDS = 3;
    localparam int                     TYPE_WORDS    = 1;

    typedef struct packed {
        logic                   tvalid;
        logic [AXIS_DATA_W-1:0] tdata;
        logic                   tlast;
    } axis_source_t;

    typedef struct packed {
        logic tready;
    } axis_sink_t;

    typedef enum logic [4:0] {
        FS_NONE    = 5'b00000,
        FS_SFD     = 5'b00001,
        FS_DST_MAC = 5'b00011,
        FS_SRC_MAC = 5'b00101,
        FS_TYPE    = 5'b01001,
        FS_PAYLOAD = 5'b10001
    } frame_status;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DST_MAC = 3'd1,
        ST_SRC_MAC = 3'd2,
        ST_TYPE    = 3'd3,
        ST_PAYLOAD = 3'd4,
        ST_DISCARD = 3'd5
    } fsm_state_t;

    // Index of the final word of a header field, as seen by the 2-bit word counter.
    function automatic logic [1:0] hdr_last_idx(input fsm_state_t s);
        case (s)
            ST_DST_MAC: return 2'(DST_MAC_WORDS - 1);
            ST_SRC_MAC: return 2'(SRC_MAC_WORDS - 1);
            ST_TYPE:    return 2'(TYPE_WORDS - 1);
            default:    return 2'd0;
        endcase
    endfunction

    function automatic fsm_state_t hdr_next(input fsm_state_t s);
        case (s)
            ST_DST_MAC: return ST_SRC_MAC;
            ST_SRC_MAC: return ST_TYPE;
            default:    return ST_PAYLOAD;
        endcase
    endfunction

endpackage

// File: rtl/egress_fsm_axis_reg_slice.sv
// Two-entry AXIS register slice: takes a word every cycle the sink is ready, so a
// toggling tready never costs throughput. Usable on either side of the frame buffer.
module axis_reg_slice
    import egress_fsm_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    input  logic [AXIS_DATA_W-1:0] in_data,
    input  logic                   in_last,
    output logic                   can_accept,
    output axis_source_t           out_source,
    input  axis_sink_t             out_sink
);

    logic [AXIS_DATA_W-1:0] data_q [2];
    logic                   last_q [2];
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             count;
    logic                   push;
    logic                   pop;

    assign pop        = (count != 2'd0) && out_sink.tready;
    assign can_accept = (count != 2'd2) || pop;
    assign push       = in_valid && can_accept;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= !wr_ptr;
            if (pop)  rd_ptr <= !rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    // Storage is never reset; the output mux zeroes it whenever the slice is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr] <= in_data;
            last_q[wr_ptr] <= in_last;
        end
    end

    always_comb begin
        out_source = '0;
        if (count != 2'd0) begin
            out_source.tvalid = 1'b1;
            out_source.tdata  = data_q[rd_ptr];
            out_source.tlast  = last_q[rd_ptr];
        end
    end

endmodule

// File: rtl/egress_fsm.sv
// Egress drainer: pops complete frames from the FWFT frame buffer, checks the SFD,
// tracks header fields and forwards good frames to AXIS through a register slice.
module egress_fsm
    import egress_fsm_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter logic [DATA_W-1:0] SFD_WORD = 16'hAAAB,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              buf_empty,
    input  logic [DATA_W-1:0] buf_rdata,
    input  logic              buf_rlast,
    input  logic              buf_frame_avail,
    output logic              buf_rd_en,
    output logic              buf_frame_done,
    input  logic              egress_en,
    output axis_source_t      egress_source,
    input  axis_sink_t        egress_sink,
    output frame_status       tx_status,
    output logic [CNT_W-1:0]  tx_frame_cnt,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic              runt_err,
    output logic              underrun_err
);

    fsm_state_t state;
    logic [1:0] hdr_cnt;
    logic       slice_can_accept;
    logic       is_sfd;
    logic       pop;
    logic       push;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        pop       = 1'b0;
        tx_status = FS_NONE;
        is_sfd    = (buf_rdata == SFD_WORD);
        case (state)
            ST_IDLE:    pop = buf_frame_avail && egress_en && !buf_empty && slice_can_accept;
            ST_DISCARD: pop = !buf_empty;
            default:    pop = !buf_empty && slice_can_accept;
        endcase
        // The buffer shares our reset, so nothing is popped while it is asserted.
        pop  = pop && reset_n;
        push = pop && (state != ST_DISCARD) && ((state != ST_IDLE) || is_sfd);
        case (state)
            ST_IDLE:    tx_status = (pop && is_sfd) ? FS_SFD : FS_NONE;
            ST_DST_MAC: tx_status = FS_DST_MAC;
            ST_SRC_MAC: tx_status = FS_SRC_MAC;
            ST_TYPE:    tx_status = FS_TYPE;
            ST_PAYLOAD: tx_status = FS_PAYLOAD;
            default:    tx_status = FS_NONE;
        endcase
    end

    assign buf_rd_en      = pop;
    assign buf_frame_done = pop && buf_rlast;

    axis_reg_slice u_slice (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (push),
        .in_data    (buf_rdata),
        .in_last    (buf_rlast),
        .can_accept (slice_can_accept),
        .out_source (egress_source),
        .out_sink   (egress_sink)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            hdr_cnt      <= 2'd0;
            tx_frame_cnt <= '0;
            drop_cnt     <= '0;
            runt_err     <= 1'b0;
            underrun_err <= 1'b0;
        end else begin
            runt_err <= 1'b0;
            if ((state != ST_IDLE) && buf_empty) underrun_err <= 1'b1;
            if (pop) begin
                case (state)
                    ST_IDLE: begin
                        hdr_cnt <= 2'd0;
                        if (is_sfd) begin
                            // A lone SFD word with rlast is treated as the shortest runt.
                            if (buf_rlast) begin
                                runt_err     <= 1'b1;
                                tx_frame_cnt <= tx_frame_cnt + CNT_W'(1);
                            end else begin
                                state <= ST_DST_MAC;
                            end
                        end else if (buf_rlast) begin
                            drop_cnt <= sat_inc(drop_cnt);
                        end else begin
                            state <= ST_DISCARD;
                        end
                    end
                    ST_DST_MAC, ST_SRC_MAC, ST_TYPE: begin
                        if (buf_rlast) begin
                            state        <= ST_IDLE;
                            hdr_cnt      <= 2'd0;
                            runt_err     <= 1'b1;
                            tx_frame_cnt <= tx_frame_cnt + CNT_W'(1);
                        end else if (hdr_cnt == hdr_last_idx(state)) begin
                            state   <= hdr_next(state);
                            hdr_cnt <= 2'd0;
                        end else begin
                            hdr_cnt <= hdr_cnt + 2'd1;
                        end
                    end
                    ST_PAYLOAD: begin
                        if (buf_rlast) begin
                            state        <= ST_IDLE;
                            tx_frame_cnt <= tx_frame_cnt + CNT_W'(1);
                        end
                    end
                    ST_DISCARD: begin
                        if (buf_rlast) begin
                            state    <= ST_IDLE;
                            drop_cnt <= sat_inc(drop_cnt);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_egress_fsm.sv
// Bench for egress_fsm: an FWFT buffer model feeds frames; expected egress words are
// queued at load time and matched against every AXIS handshake.
module tb_egress_fsm;
    import egress_fsm_pkg::*;

    localparam int          CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [15:0] SFD_W   = 16'hAAAB;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } word_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              buf_empty;
    logic [15:0]       buf_rdata;
    logic              buf_rlast;
    logic              buf_frame_avail;
    logic              buf_rd_en;
    logic              buf_frame_done;
    logic              egress_en;
    axis_source_t      egress_source;
    axis_sink_t        egress_sink;
    frame_status       tx_status;
    logic [CNT_W-1:0]  tx_frame_cnt;
    logic [CNT_W-1:0]  drop_cnt;
    logic              runt_err;
    logic              underrun_err;

    always #5 clk = ~clk;

    egress_fsm #(.DATA_W(16), .SFD_WORD(16'hAAAB), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .buf_empty       (buf_empty),
        .buf_rdata       (buf_rdata),
        .buf_rlast       (buf_rlast),
        .buf_frame_avail (buf_frame_avail),
        .buf_rd_en       (buf_rd_en),
        .buf_frame_done  (buf_frame_done),
        .egress_en       (egress_en),
        .egress_source   (egress_source),
        .egress_sink     (egress_sink),
        .tx_status       (tx_status),
        .tx_frame_cnt    (tx_frame_cnt),
        .drop_cnt        (drop_cnt),
        .runt_err        (runt_err),
        .underrun_err    (underrun_err)
    );

    word_t       bq[$];
    word_t       exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          complete = 0;
    int          force_avail = 0;
    int          ld_pos = 0;
    logic        ld_good = 1'b0;
    int          pop_pos = 0;
    logic        pop_good = 1'b0;
    int          pops_total = 0;
    int          exp_tx = 0;
    int          exp_drop = 0;
    int          exp_runt = 0;
    int          runt_cnt = 0;
    int          cyc = 0;
    int          fires_win = 0;
    int          first_fire = 0;
    int          last_fire = 0;
    int          ready_mode = 0;
    logic [3:0]  rdy_pat = 4'b1001;
    logic        prev_stall = 1'b0;
    logic [16:0] prev_word = '0;
    int          base_pops = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    endtask

    function automatic logic [4:0] exp_status(input int pos, input logic good);
        if (!good)    return 5'b00000;
        if (pos == 0) return 5'b00001;
        if (pos <= 3) return 5'b00011;
        if (pos <= 6) return 5'b00101;
        if (pos == 7) return 5'b01001;
        return 5'b10001;
    endfunction

    task automatic drive_buf();
        buf_empty       = (bq.size() == 0);
        buf_rdata       = buf_empty ? 16'h0 : bq[0].d;
        buf_rlast       = buf_empty ? 1'b0 : bq[0].l;
        buf_frame_avail = (complete > 0) || (force_avail != 0);
    endtask

    task automatic put_word(input logic [15:0] d, input logic l);
        word_t w;
        w.d = d;
        w.l = l;
        if (ld_pos == 0) ld_good = (d == SFD_W);
        bq.push_back(w);
        if (ld_good) exp_q.push_back(w);
        if (l) begin
            complete++;
            if (ld_good) begin
                exp_tx++;
                if (ld_pos <= 7) exp_runt++;
            end else begin
                exp_drop++;
            end
            ld_pos = 0;
        end else begin
            ld_pos++;
        end
        drive_buf();
    endtask

    function automatic word_t frame_word(input int i, input int n_pay, input logic [15:0] last_w,
                                         input logic [15:0] seed);
        word_t w;
        int    n;
        n   = 8 + n_pay;
        w.l = (i == n - 1);
        if (i == 0)          w.d = 16'hAAAB;
        else if (i <= 6)     w.d = 16'h0A00 + 16'(i);
        else if (i == 7)     w.d = 16'h0800;
        else if (i == n - 1) w.d = last_w;
        else                 w.d = seed + 16'(i);
        return w;
    endfunction

    task automatic load_range(input int from, input int to, input int n_pay,
                              input logic [15:0] last_w, input logic [15:0] seed);
        word_t w;
        for (int i = from; i <= to; i++) begin
            w = frame_word(i, n_pay, last_w, seed);
            put_word(w.d, w.l);
        end
    endtask

    task automatic load_frame(input int n_pay, input logic [15:0] last_w, input logic [15:0] seed);
        load_range(0, 7 + n_pay, n_pay, last_w, seed);
    endtask

    task automatic cycle();
        logic  do_pop;
        word_t w;
        do_pop = 1'b0;
        @(negedge clk);
        if (reset_n) begin
            check_eq("rd_when_empty", 32'(buf_rd_en && (bq.size() == 0)), 32'd0);
            if (buf_rd_en && (bq.size() != 0)) begin
                do_pop = 1'b1;
                if (pop_pos == 0) pop_good = (bq[0].d == SFD_W);
                check_eq("tx_status", 32'(tx_status), 32'(exp_status(pop_pos, pop_good)));
                check_eq("frame_done", 32'(buf_frame_done), 32'(bq[0].l));
                pop_pos = bq[0].l ? 0 : pop_pos + 1;
                pops_total++;
            end else begin
                check_eq("frame_done_nopop", 32'(buf_frame_done), 32'd0);
            end
            if (runt_err) runt_cnt++;
            if (prev_stall) begin
                check_eq("tvalid_hold", 32'(egress_source.tvalid), 32'd1);
                if (egress_source.tvalid)
                    check_eq("hold_data", 32'({egress_source.tlast, egress_source.tdata}), 32'(prev_word));
            end
            prev_stall = egress_source.tvalid && !egress_sink.tready;
            prev_word  = {egress_source.tlast, egress_source.tdata};
            if (egress_source.tvalid && egress_sink.tready) begin
                if (fires_win == 0) first_fire = cyc;
                last_fire = cyc;
                fires_win++;
                if (exp_q.size() == 0) begin
                    check_eq("egress_extra_word", 32'({egress_source.tlast, egress_source.tdata}), 32'hFFFF_FFFF);
                end else begin
                    w = exp_q.pop_front();
                    check_eq("egress_word", 32'({egress_source.tlast, egress_source.tdata}), 32'({w.l, w.d}));
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (do_pop) begin
            w = bq.pop_front();
            if (w.l) complete--;
        end
        egress_sink.tready = (ready_mode == 0) ? 1'b1 : rdy_pat[2'(cyc % 4)];
        drive_buf();
    endtask

    task automatic drain(input int max);
        int i;
        i = 0;
        while (((bq.size() != 0) || (exp_q.size() != 0)) && (i < max)) begin
            cycle();
            i++;
        end
        check_eq("drain_left", 32'(bq.size() + exp_q.size()), 32'd0);
        repeat (3) cycle();
    endtask

    task automatic run_until_pops(input int target, input int max);
        int i;
        i = 0;
        while ((pops_total < target) && (i < max)) begin
            cycle();
            i++;
        end
        check_eq("pop_target", 32'(pops_total >= target), 32'd1);
    endtask

    task automatic checkpoint();
        check_eq("tx_frame_cnt", 32'(tx_frame_cnt), 32'(exp_tx % (CNT_MAX + 1)));
        check_eq("drop_cnt", 32'(drop_cnt), 32'((exp_drop > CNT_MAX) ? CNT_MAX : exp_drop));
        check_eq("runt_pulses", 32'(runt_cnt), 32'(exp_runt));
        check_eq("egress_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bq.delete();
        exp_q.delete();
        complete    = 0;
        force_avail = 0;
        ld_pos      = 0;
        pop_pos     = 0;
        exp_tx      = 0;
        exp_drop    = 0;
        exp_runt    = 0;
        runt_cnt    = 0;
        prev_stall  = 1'b0;
        drive_buf();
        cycle();
        reset_n = 1'b1;
        #1;
        check_eq("rst_tvalid", 32'(egress_source.tvalid), 32'd0);
        check_eq("rst_tdata", 32'(egress_source.tdata), 32'd0);
        check_eq("rst_tlast", 32'(egress_source.tlast), 32'd0);
        check_eq("rst_rd_en", 32'(buf_rd_en), 32'd0);
        check_eq("rst_frame_done", 32'(buf_frame_done), 32'd0);
        check_eq("rst_tx_status", 32'(tx_status), 32'd0);
        check_eq("rst_tx_frame_cnt", 32'(tx_frame_cnt), 32'd0);
        check_eq("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check_eq("rst_runt_err", 32'(runt_err), 32'd0);
        check_eq("rst_underrun_err", 32'(underrun_err), 32'd0);
    endtask

    initial begin
        reset_n            = 1'b0;
        egress_en          = 1'b1;
        egress_sink.tready = 1'b1;
        drive_buf();
        do_reset();

        // Good 11-word frame at full rate
        fires_win = 0;
        load_frame(3, 16'hBEEF, 16'h1000);
        drain(100);
        check_eq("t1_words", 32'(fires_win), 32'd11);
        check_eq("t1_no_gap", 32'(last_fire - first_fire), 32'd10);
        checkpoint();

        // Same frame with tready toggling 1,0,0,1
        ready_mode = 1;
        load_frame(3, 16'hBEEF, 16'h1000);
        drain(200);
        checkpoint();
        ready_mode         = 0;
        egress_sink.tready = 1'b1;

        // Frame with a bad first word is discarded, then a good one follows
        base_pops = pops_total;
        fires_win = 0;
        put_word(16'h1234, 1'b0);
        put_word(16'h0001, 1'b0);
        put_word(16'h0002, 1'b0);
        put_word(16'h0003, 1'b0);
        put_word(16'h0004, 1'b1);
        repeat (12) cycle();
        check_eq("t3_pops", 32'(pops_total - base_pops), 32'd5);
        check_eq("t3_no_tvalid", 32'(fires_win), 32'd0);
        checkpoint();
        load_frame(2, 16'hC0DE, 16'h2000);
        drain(100);
        checkpoint();

        // Runt frame ending in DST_MAC
        put_word(16'hAAAB, 1'b0);
        put_word(16'h1111, 1'b0);
        put_word(16'h2222, 1'b1);
        drain(50);
        checkpoint();

        // egress_en drops on payload word 2; the next frame must wait
        load_frame(4, 16'hD00D, 16'h3000);
        load_frame(3, 16'hE00E, 16'h4000);
        run_until_pops(pops_total + 10, 100);
        egress_en = 1'b0;
        repeat (40) cycle();
        check_eq("t5_held_exp", 32'(exp_q.size()), 32'd11);
        check_eq("t5_held_buf", 32'(bq.size()), 32'd11);
        check_eq("t5_tx_cnt", 32'(tx_frame_cnt), 32'((exp_tx - 1) % (CNT_MAX + 1)));
        egress_en = 1'b1;
        drain(100);
        checkpoint();

        // Reset mid-payload, then an underrun stall in a later frame
        load_frame(3, 16'hBEEF, 16'h5000);
        run_until_pops(pops_total + 10, 100);
        do_reset();
        fires_win   = 0;
        force_avail = 1;
        load_range(0, 4, 3, 16'hBEEF, 16'h6000);
        repeat (12) cycle();
        check_eq("t6_underrun_set", 32'(underrun_err), 32'd1);
        check_eq("t6_words_before_stall", 32'(fires_win), 32'd5);
        force_avail = 0;
        load_range(5, 10, 3, 16'hBEEF, 16'h6000);
        drain(100);
        checkpoint();
        check_eq("t6_underrun_sticky", 32'(underrun_err), 32'd1);
        do_reset();

        // Counter boundaries: drop_cnt saturates, tx_frame_cnt wraps
        for (int i = 0; i < 16; i++) put_word(16'h1234, 1'b1);
        for (int i = 0; i < 16; i++) begin
            put_word(16'hAAAB, 1'b0);
            put_word(16'h1111, 1'b1);
        end
        drain(400);
        checkpoint();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
